// File: rtl/pixel_fifo_pkg.sv
// Shared definitions for the pixel FIFO read side: word layout, flag positions, FSM states.
// Flag bits sit directly above the payload in each FIFO word.
package pixel_fifo_pkg;

   localparam int DATA_WIDTH_DEF = 35;
   localparam int PAYLOAD_W_DEF  = 32;
   localparam int CNT_W_DEF      = 16;

   localparam int FLAG_SOF = 34;
   localparam int FLAG_EOL = 33;
   localparam int FLAG_EOF = 32;

   typedef enum logic {
      IDLE = 1'b0,
      POP  = 1'b1
   } rd_state_t;

   typedef struct packed {
      logic sof;
      logic eol;
      logic eof;
   } frame_flags_t;

endpackage

// File: rtl/fifo_rd_outreg.sv
// Output holding register: loads one word when the slot is free; the word stays put until out_ready is seen.
// Zero-latency accept; a new load may replace a word in the same cycle that word is accepted.
module fifo_rd_outreg
   import pixel_fifo_pkg::*;
#(
   parameter int PAYLOAD_W = PAYLOAD_W_DEF
)(
   input  logic                 clk_rd,
   input  logic                 rst,
   input  logic                 clear,
   input  logic                 load,
   input  logic [PAYLOAD_W-1:0] load_data,
   input  frame_flags_t         load_flags,
   input  logic                 out_ready,
   output logic [PAYLOAD_W-1:0] out_data,
   output frame_flags_t         out_flags,
   output logic                 out_valid,
   output logic                 accept,
   output logic                 slot_free
);

   assign accept    = out_valid & out_ready;
   assign slot_free = ~out_valid | out_ready;

   always_ff @(posedge clk_rd or posedge rst) begin
      if (rst) begin
         out_data  <= '0;
         out_flags <= '0;
         out_valid <= 1'b0;
      end else if (clear) begin
         out_data  <= '0;
         out_flags <= '0;
         out_valid <= 1'b0;
      end else if (load) begin
         out_data  <= load_data;
         out_flags <= load_flags;
         out_valid <= 1'b1;
      end else if (accept) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/fifo_stream_reader.sv
// Pops the pixel FIFO with single-cycle rden pulses (max 1 word / 2 cycles, 1-cycle pop-to-valid)
// and streams payload+flags downstream; stalls popping while out_valid & !out_ready.
module fifo_stream_reader
   import pixel_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int PAYLOAD_W  = PAYLOAD_W_DEF,
   parameter int CNT_W      = CNT_W_DEF
)(
   input  logic                  clk_rd,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  clear,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   input  logic                  fifo_empty,
   output logic                  fifo_rden,
   output logic [PAYLOAD_W-1:0]  out_data,
   output logic                  out_sof,
   output logic                  out_eol,
   output logic                  out_eof,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [CNT_W-1:0]      word_count,
   output logic                  underrun,
   output logic [CNT_W-1:0]      underrun_count
);

   rd_state_t    state_q, state_d;
   logic         load;
   logic         accept;
   logic         slot_free;
   logic         in_frame;
   logic         eol_prev;
   logic         starve;
   frame_flags_t head_flags;
   frame_flags_t out_flags;

   assign head_flags.sof = fifo_data[FLAG_SOF];
   assign head_flags.eol = fifo_data[FLAG_EOL];
   assign head_flags.eof = fifo_data[FLAG_EOF];

   // The FIFO needs rden to drop between pops, so a load always passes through POP.
   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      case (state_q)
         IDLE: begin
            if (enable && !fifo_empty && slot_free && !clear) begin
               load    = 1'b1;
               state_d = POP;
            end
         end
         POP:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_rd or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         fifo_rden <= 1'b0;
      end else if (clear) begin
         state_q   <= IDLE;
         fifo_rden <= 1'b0;
      end else begin
         state_q   <= state_d;
         fifo_rden <= load;
      end
   end

   fifo_rd_outreg #(
      .PAYLOAD_W (PAYLOAD_W)
   ) u_outreg (
      .clk_rd     (clk_rd),
      .rst        (rst),
      .clear      (clear),
      .load       (load),
      .load_data  (fifo_data[PAYLOAD_W-1:0]),
      .load_flags (head_flags),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_flags  (out_flags),
      .out_valid  (out_valid),
      .accept     (accept),
      .slot_free  (slot_free)
   );

   assign out_sof = out_flags.sof;
   assign out_eol = out_flags.eol;
   assign out_eof = out_flags.eof;

   assign starve = in_frame & enable & out_ready & ~out_valid & fifo_empty;

   always_ff @(posedge clk_rd or posedge rst) begin
      if (rst) begin
         word_count     <= '0;
         eol_prev       <= 1'b0;
         in_frame       <= 1'b0;
         underrun       <= 1'b0;
         underrun_count <= '0;
      end else if (clear) begin
         word_count     <= '0;
         eol_prev       <= 1'b0;
         in_frame       <= 1'b0;
         underrun       <= 1'b0;
         underrun_count <= '0;
      end else begin
         if (accept) begin
            // A line restarts on sof or on the word after an eol.
            if (out_flags.sof || eol_prev)
               word_count <= CNT_W'(1);
            else
               word_count <= word_count + CNT_W'(1);
            eol_prev <= out_flags.eol;
            if (out_flags.eof)
               in_frame <= 1'b0;
            else if (out_flags.sof)
               in_frame <= 1'b1;
         end
         if (starve) begin
            underrun <= 1'b1;
            if (underrun_count != '1)
               underrun_count <= underrun_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: show-ahead FIFO model, queue scoreboard with line-position model,
// directed scenarios plus randomized traffic.
module tb_fifo_stream_reader;
   import pixel_fifo_pkg::*;

   localparam int DW    = 35;
   localparam int PW    = 32;
   localparam int CW    = 16;
   localparam int DEPTH = 16;

   logic          clk_rd    = 1'b0;
   logic          rst       = 1'b0;
   logic          enable    = 1'b0;
   logic          clear     = 1'b0;
   logic          out_ready = 1'b0;
   logic [DW-1:0] fifo_data;
   logic          fifo_empty;
   logic          fifo_rden;
   logic [PW-1:0] out_data;
   logic          out_sof, out_eol, out_eof, out_valid;
   logic [CW-1:0] word_count, underrun_count;
   logic          underrun;

   always #5 clk_rd = ~clk_rd;

   fifo_stream_reader #(.DATA_WIDTH(DW), .PAYLOAD_W(PW), .CNT_W(CW)) dut (
      .clk_rd         (clk_rd),
      .rst            (rst),
      .enable         (enable),
      .clear          (clear),
      .fifo_data      (fifo_data),
      .fifo_empty     (fifo_empty),
      .fifo_rden      (fifo_rden),
      .out_data       (out_data),
      .out_sof        (out_sof),
      .out_eol        (out_eol),
      .out_eof        (out_eof),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .word_count     (word_count),
      .underrun       (underrun),
      .underrun_count (underrun_count)
   );

   // show-ahead FIFO: advances on a sampled rden rising edge, cleared by the same clear pulse
   logic [DW-1:0] mem [DEPTH];
   logic [4:0]    wrptr, rdptr;
   logic          rden_q;
   logic          wr_en   = 1'b0;
   logic [DW-1:0] wr_data = '0;

   always @(posedge clk_rd or posedge rst) begin
      if (rst) begin
         wrptr  <= '0;
         rdptr  <= '0;
         rden_q <= 1'b0;
      end else if (clear) begin
         wrptr  <= '0;
         rdptr  <= '0;
         rden_q <= 1'b0;
      end else begin
         rden_q <= fifo_rden;
         if (fifo_rden && !rden_q) rdptr <= rdptr + 5'd1;
         if (wr_en) begin
            mem[wrptr[3:0]] <= wr_data;
            wrptr <= wrptr + 5'd1;
         end
      end
   end
   assign fifo_data  = mem[rdptr[3:0]];
   assign fifo_empty = (wrptr == rdptr);

   typedef struct packed {
      logic [PW-1:0] data;
      logic          sof, eol, eof;
      logic [CW-1:0] wc;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   m_wc;
   bit   m_eol;
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // every written word will eventually be accepted in order, so its line position is known now
   function automatic void model_push(input logic [PW-1:0] d, input bit s, input bit l, input bit f);
      exp_t e;
      if (s || m_eol) m_wc = 1;
      else            m_wc = (m_wc + 1) % (1 << CW);
      m_eol = l;
      e.data = d; e.sof = s; e.eol = l; e.eof = f; e.wc = CW'(m_wc);
      exp_q.push_back(e);
   endfunction

   function automatic void model_reset();
      exp_q.delete();
      m_wc  = 0;
      m_eol = 0;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk_rd);
      #1;
   endtask

   task automatic write_word(input logic [PW-1:0] d, input bit s, input bit l, input bit f);
      wr_data = {s, l, f, d};
      wr_en   = 1'b1;
      model_push(d, s, l, f);
      tick(1);
      wr_en = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      wr_en = 1'b0;
      model_reset();
      tick(1);
      clear = 1'b0;
   endtask

   task automatic wait_drain(input string name, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (exp_q.size() == 0) break;
         tick(1);
      end
      check(name, exp_q.size(), 0);
      tick(2);
   endtask

   // monitor: pops on each handshake; word_count is checked the cycle after acceptance
   initial begin : monitor
      bit            pend;
      bit            rden_prev;
      logic [CW-1:0] pend_wc;
      pend      = 0;
      rden_prev = 0;
      pend_wc   = '0;
      forever begin
         @(negedge clk_rd);
         if (rst) begin
            pend      = 0;
            rden_prev = 0;
            continue;
         end
         if (pend) begin
            check("word_count", word_count, pend_wc);
            pend = 0;
         end
         if (fifo_rden) check("rden_single_pulse", rden_prev, 0);
         rden_prev = fifo_rden;
         if (out_valid && out_ready && !clear) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_word: got %0h, expected none", out_data);
            end else begin
               mon_e = exp_q.pop_front();
               check("out_data", out_data, mon_e.data);
               check("out_flags", {out_sof, out_eol, out_eof}, {mon_e.sof, mon_e.eol, mon_e.eof});
               pend_wc = mon_e.wc;
               pend    = 1;
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d checks done", n_tests);
      $fatal(1, "watchdog");
   end

   initial begin : stim
      logic [PW-1:0] w0;
      int            pops;
      logic [4:0]    occ;
      bit            s, l, f;
      model_reset();

      // reset state
      #2 rst = 1'b1;
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_fifo_rden", fifo_rden, 0);
      check("rst_word_count", word_count, 0);
      check("rst_underrun", {underrun, underrun_count}, 0);
      @(posedge clk_rd);
      @(posedge clk_rd);
      #1 rst = 1'b0;

      // 1: four words, free-running downstream
      for (int i = 0; i < 4; i++) write_word(32'hA000_0000 + i, 0, 0, 0);
      out_ready = 1'b1;
      enable    = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         tick(1);
         check($sformatf("t1_rden_c%0d", c), fifo_rden, ((c % 2) == 1) && (c <= 7));
      end
      check("t1_rdptr", rdptr, 4);
      check("t1_empty", fifo_empty, 1);
      tick(2);
      enable = 1'b0;
      do_clear();

      // 2: downstream stalled, exactly one pop and held data
      out_ready = 1'b0;
      w0 = $urandom;
      write_word(w0, 0, 0, 0);
      write_word($urandom, 0, 0, 0);
      write_word($urandom, 0, 0, 0);
      enable = 1'b1;
      pops   = 0;
      for (int c = 0; c < 10; c++) begin
         tick(1);
         if (fifo_rden) pops++;
      end
      check("t2_pops_stalled", pops, 1);
      check("t2_held_valid", out_valid, 1);
      check("t2_held_data", out_data, w0);
      out_ready = 1'b1;
      wait_drain("t2_drain", 40);
      enable = 1'b0;
      do_clear();

      // 3: line/frame flags
      write_word($urandom, 1, 0, 0);
      write_word($urandom, 0, 0, 0);
      write_word($urandom, 0, 0, 0);
      write_word($urandom, 0, 1, 0);
      write_word($urandom, 0, 0, 0);
      write_word($urandom, 0, 0, 1);
      out_ready = 1'b1;
      enable    = 1'b1;
      wait_drain("t3_drain", 60);
      tick(6);
      check("t3_word_count_end", word_count, 2);
      check("t3_no_underrun", {underrun, underrun_count}, 0);
      enable = 1'b0;
      do_clear();

      // 4: starvation inside a frame
      write_word($urandom, 1, 0, 0);
      out_ready = 1'b1;
      enable    = 1'b1;
      tick(2);
      check("t4_accepted", out_valid, 0);
      tick(5);
      enable = 1'b0;
      check("t4_underrun", underrun, 1);
      check("t4_underrun_count", underrun_count, 5);
      do_clear();
      check("t4_clr_underrun", {underrun, underrun_count}, 0);

      // 5: clear during POP
      out_ready = 1'b0;
      write_word($urandom, 0, 0, 0);
      write_word($urandom, 0, 0, 0);
      enable = 1'b1;
      tick(1);
      check("t5_in_pop", fifo_rden, 1);
      do_clear();
      check("t5_rden_after_clr", fifo_rden, 0);
      check("t5_valid_after_clr", out_valid, 0);
      check("t5_ptrs_after_clr", {wrptr, rdptr}, 0);
      write_word($urandom, 0, 1, 0);
      out_ready = 1'b1;
      wait_drain("t5_drain", 20);
      check("t5_rdptr", rdptr, 1);

      // randomized traffic
      do_clear();
      for (int c = 0; c < 1500; c++) begin
         enable    = ($urandom_range(0, 7) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         occ       = wrptr - rdptr;
         if ($urandom_range(0, 199) == 0) begin
            clear = 1'b1;
            model_reset();
         end else if ($urandom_range(0, 1) == 1 && occ < 5'd14) begin
            s = ($urandom_range(0, 7) == 0);
            l = ($urandom_range(0, 3) == 0);
            f = ($urandom_range(0, 7) == 0);
            wr_data = {s, l, f, PW'($urandom)};
            wr_en   = 1'b1;
            model_push(wr_data[PW-1:0], s, l, f);
         end
         tick(1);
         wr_en = 1'b0;
         clear = 1'b0;
      end
      enable    = 1'b1;
      out_ready = 1'b1;
      wait_drain("rand_drain", 200);

      // 6: async reset mid-stream
      enable = 1'b0;
      do_clear();
      write_word($urandom, 1, 0, 0);
      enable = 1'b1;
      tick(5);
      out_ready = 1'b0;
      write_word($urandom, 0, 0, 0);
      write_word($urandom, 0, 0, 0);
      tick(3);
      check("t6_pre_valid", out_valid, 1);
      check("t6_pre_underrun_count", underrun_count, 3);
      #2 rst = 1'b1;
      model_reset();
      #1;
      check("t6_valid", out_valid, 0);
      check("t6_rden", fifo_rden, 0);
      check("t6_data_flags", {out_data, out_sof, out_eol, out_eof}, 0);
      check("t6_counts", {word_count, underrun, underrun_count}, 0);
      tick(2);
      rst = 1'b0;
      tick(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
